// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
//
// Purpose:
//    Shared constants, types and helpers for the score binary-to-BCD
//    converter. The converter turns the game's binary score or hit counter
//    into four BCD digits for the per-digit seven-segment decoders.
//
// Contents:
//    BIN_W       width of the binary score input (2^14 covers 0..9999)
//    DIGITS      number of BCD digits produced
//    MAX_VAL     saturation limit, which has to be 10^DIGITS - 1 so the
//                clamped value always fits in DIGITS decimal digits
//    BCD_W       width of the packed BCD output word
//    SREG_W      width of the combined {bcd, bin} double-dabble register
//    CNT_W       width of the shift counter, $clog2(BIN_W)
//    BLANK_CODE  nibble the downstream decoder shows as all segments off
//    state_t     converter FSM states {IDLE, SHIFT}
//    blankLeadingZeros()  replaces leading zero digits with BLANK_CODE
//
// Build option:
//    SCORE_LEADING_ZERO_BLANK_EN selects leading-zero blanking in the top
//    module; the helper here is always available.
// ---------------------------------------------------------------------------
package score_pkg;

   localparam int BIN_W   = 14;
   localparam int DIGITS  = 4;
   localparam int MAX_VAL = 9999;

   localparam int BCD_W   = 4 * DIGITS;
   localparam int SREG_W  = BCD_W + BIN_W;
   localparam int CNT_W   = $clog2(BIN_W);

   localparam logic [3:0] BLANK_CODE = 4'hF;

   // Saturation limit sized to the binary input so comparisons against
   // bin_in stay the same width on both sides.
   localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

   // Counter value at which the last of the BIN_W shifts happens.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Walks from the most significant digit downwards and blanks digits
   // while they are still zero. Digit 0 is never touched, so a value of
   // zero keeps a single visible "0".
   function automatic logic [BCD_W-1:0] blankLeadingZeros(input logic [BCD_W-1:0] digits);
      logic [BCD_W-1:0] result;
      logic             seenNonZero;
      result      = digits;
      seenNonZero = 1'b0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (!seenNonZero && (digits[4*i +: 4] == 4'd0)) begin
            result[4*i +: 4] = BLANK_CODE;
         end else begin
            seenNonZero = 1'b1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/bcd_add3_adjust.sv
// ---------------------------------------------------------------------------
// bcd_add3_adjust
//
// Purpose:
//    Combinational per-digit correction step of the shift-and-add-3
//    (double dabble) algorithm. A BCD digit of 5 or more would overflow
//    past 9 when the register is doubled, so it is pre-corrected by +3
//    before the shift.
//
// Ports:
//    digit_i   4-bit BCD digit before the shift
//    digit_o   4-bit digit after the conditional +3 adjustment
// ---------------------------------------------------------------------------
module bcd_add3_adjust (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   // Only digits 5..9 can occur here in normal operation; the adjusted
   // result 8..12 then shifts into a correct carry plus low digit.
   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule

// File: rtl/score_bcd_converter.sv
// ---------------------------------------------------------------------------
// score_bcd_converter
//
// Purpose:
//    Sequential binary-to-BCD converter for the score display. A load
//    request captures the binary score (clamped to MAX_VAL), then BIN_W
//    shift-and-add-3 steps produce DIGITS BCD digits. The display output
//    only changes on the single edge that finishes a conversion, so the
//    game logic may request updates on any cycle without the display ever
//    showing partially converted digits.
//
// Ports:
//    clk       system clock, all state updates on the rising edge
//    rst       synchronous active-high reset, aborts any conversion
//    load      conversion request, only sampled while not busy
//    bin_in    binary value to convert
//    busy      high while a conversion is running
//    valid     one-cycle pulse when bcd_out and sat have been updated
//    bcd_out   packed BCD result, digit i in bits [4i+3:4i], digit 0 = units
//    sat       last accepted bin_in was above MAX_VAL and was clamped
//
// Build option:
//    SCORE_LEADING_ZERO_BLANK_EN  when defined, digits above the most
//    significant non-zero digit are written as BLANK_CODE. When undefined,
//    leading zeros are shown as 0.
// ---------------------------------------------------------------------------
module score_bcd_converter
   import score_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             valid,
   output logic [BCD_W-1:0] bcd_out,
   output logic             sat
);

   state_t            state_q,      state_d;
   logic [SREG_W-1:0] shiftReg_q,   shiftReg_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic [BCD_W-1:0]  bcdOut_q,     bcdOut_d;
   logic              sat_q,        sat_d;
   logic              satPending_q, satPending_d;
   logic              valid_q,      valid_d;

   logic [BCD_W-1:0]  adjBcd;
   logic [SREG_W-1:0] adjReg;
   logic [SREG_W-1:0] shiftedReg;
   logic [BCD_W-1:0]  finalBcd;
   logic              overLimit;
   logic [BIN_W-1:0]  clampedBin;

   // One add-3 adjuster per BCD digit of the shift register. The BCD half
   // sits above the binary half, so digit g starts at bit BIN_W + 4g.
   for (genvar g = 0; g < DIGITS; g++) begin : gen_adjust
      bcd_add3_adjust u_adjust (
         .digit_i (shiftReg_q[BIN_W + 4*g +: 4]),
         .digit_o (adjBcd[4*g +: 4])
      );
   end

   // One double-dabble step: corrected digits on top of the untouched
   // binary half, then the whole register moves left by one bit. On the
   // last step the top BCD_W bits are the finished conversion.
   assign adjReg     = {adjBcd, shiftReg_q[BIN_W-1:0]};
   assign shiftedReg = adjReg << 1;
   assign finalBcd   = shiftedReg[SREG_W-1 -: BCD_W];

   // Input clamping happens at load time so the shift datapath never sees
   // a value that needs more than DIGITS decimal digits.
   assign overLimit  = (bin_in > MAX_BIN);
   assign clampedBin = overLimit ? MAX_BIN : bin_in;

   // State register and all datapath registers. Reset clears everything,
   // which also drops any in-flight conversion without a valid pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         shiftReg_q   <= '0;
         cnt_q        <= '0;
         bcdOut_q     <= '0;
         sat_q        <= 1'b0;
         satPending_q <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         shiftReg_q   <= shiftReg_d;
         cnt_q        <= cnt_d;
         bcdOut_q     <= bcdOut_d;
         sat_q        <= sat_d;
         satPending_q <= satPending_d;
         valid_q      <= valid_d;
      end
   end

   // Next-state and datapath control. In IDLE a load starts a new
   // conversion; in SHIFT one adjust-and-shift step runs per cycle and the
   // visible outputs are only written on the final step. A load arriving
   // while in SHIFT is simply not looked at, so nothing gets queued. Since
   // valid is high in the first IDLE cycle after a conversion, a load in
   // that cycle is accepted and conversions can run back to back.
   always_comb begin
      state_d      = state_q;
      shiftReg_d   = shiftReg_q;
      cnt_d        = cnt_q;
      bcdOut_d     = bcdOut_q;
      sat_d        = sat_q;
      satPending_d = satPending_q;
      valid_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (load) begin
               shiftReg_d   = {{BCD_W{1'b0}}, clampedBin};
               cnt_d        = '0;
               satPending_d = overLimit;
               state_d      = SHIFT;
            end
         end

         SHIFT: begin
            shiftReg_d = shiftedReg;
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
`ifdef SCORE_LEADING_ZERO_BLANK_EN
               bcdOut_d = blankLeadingZeros(finalBcd);
`else
               bcdOut_d = finalBcd;
`endif
               sat_d    = satPending_q;
               valid_d  = 1'b1;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs come straight from registers, so busy/valid/bcd_out/sat are
   // glitch-free for the display and the game logic.
   assign busy    = (state_q == SHIFT);
   assign valid   = valid_q;
   assign bcd_out = bcdOut_q;
   assign sat     = sat_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_score_bcd_converter
//
// Purpose:
//    Self-checking bench for score_bcd_converter. Expected results are
//    produced by a decimal reference model, pushed to a scoreboard queue
//    when a load is driven and popped when the converter reports valid.
//    Honours SCORE_LEADING_ZERO_BLANK_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_score_bcd_converter;
   import score_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             load;
   logic [BIN_W-1:0] bin_in;
   logic             busy;
   logic             valid;
   logic [BCD_W-1:0] bcd_out;
   logic             sat;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [BCD_W-1:0] bcd;
      logic             sat;
      int               val;
   } exp_t;

   exp_t sb[$];

   score_bcd_converter dut (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .bin_in  (bin_in),
      .busy    (busy),
      .valid   (valid),
      .bcd_out (bcd_out),
      .sat     (sat)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Absolute time limit so a stuck design can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Decimal reference: clamp, then split into digits by division.
   function automatic exp_t model(input int v);
      exp_t e;
      int   m;
      int   p;
      m     = (v > 9999) ? 9999 : v;
      e.val = v;
      e.sat = (v > 9999);
      e.bcd = '0;
      p     = 1;
      for (int d = 0; d < DIGITS; d++) begin
         e.bcd[4*d +: 4] = 4'((m / p) % 10);
         p = p * 10;
      end
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      begin
         logic seen;
         seen = 1'b0;
         for (int d = DIGITS - 1; d > 0; d--) begin
            if (!seen && (e.bcd[4*d +: 4] == 4'd0)) e.bcd[4*d +: 4] = 4'hF;
            else seen = 1'b1;
         end
      end
`endif
      return e;
   endfunction

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Step cycles until valid is seen or the budget runs out.
   task automatic waitForValid(input int maxCycles, output int cycles);
      cycles = 0;
      while ((valid !== 1'b1) && (cycles < maxCycles)) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      load   = 1'b0;
      bin_in = '0;
      tick();
      tick();
      rst = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
      total++; if (bcd_out !== 16'h0000) begin bad++; $display("[TB] FAIL reset_bcd: got %h want 0000", bcd_out); end
      total++; if (sat !== 1'b0) begin bad++; $display("[TB] FAIL reset_sat: got %b want 0", sat); end
   endtask

   task automatic test_basic();
      exp_t e;
      e = model(1234);
      sb.push_back(e);
      load   = 1'b1;
      bin_in = 14'd1234;
      tick();
      load = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy c=%0d: got %b want 1", c, busy); end
         total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid c=%0d: got %b want 0", c, valid); end
         total++; if (bcd_out !== 16'h0000) begin bad++; $display("[TB] FAIL basic_hold c=%0d: got %h want 0000", c, bcd_out); end
         tick();
      end
      total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid: got %b want 1", valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_end: got %b want 0", busy); end
      total++;
      if (sb.size() == 0) begin
         bad++; $display("[TB] FAIL basic_sb: got 0 entries want 1");
      end else begin
         e = sb.pop_front();
         total++; if (bcd_out !== e.bcd) begin bad++; $display("[TB] FAIL basic_bcd: got %h want %h", bcd_out, e.bcd); end
         total++; if (sat !== e.sat) begin bad++; $display("[TB] FAIL basic_sat: got %b want %b", sat, e.sat); end
      end
      tick();
      total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_pulse_len: got %b want 0", valid); end
   endtask

   task automatic test_boundaries();
      int   vals[3] = '{0, 9999, 16383};
      exp_t e;
      int   cyc;
      for (int i = 0; i < 3; i++) begin
         e = model(vals[i]);
         sb.push_back(e);
         load   = 1'b1;
         bin_in = BIN_W'(vals[i]);
         tick();
         load = 1'b0;
         waitForValid(20, cyc);
         total++;
         if ((valid !== 1'b1) || (cyc != 14)) begin
            bad++; $display("[TB] FAIL bound_latency v=%0d: got valid=%b after %0d cycles want valid=1 after 14", vals[i], valid, cyc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            total++; if (bcd_out !== e.bcd) begin bad++; $display("[TB] FAIL bound_bcd v=%0d: got %h want %h", e.val, bcd_out, e.bcd); end
            total++; if (sat !== e.sat) begin bad++; $display("[TB] FAIL bound_sat v=%0d: got %b want %b", e.val, sat, e.sat); end
         end
      end
   endtask

   task automatic test_reset_mid_conversion();
      int pulses;
      load   = 1'b1;
      bin_in = 14'd1234;
      tick();
      load = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
      total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid: got %b want 0", valid); end
      total++; if (bcd_out !== 16'h0000) begin bad++; $display("[TB] FAIL midrst_bcd: got %h want 0000", bcd_out); end
      total++; if (sat !== 1'b0) begin bad++; $display("[TB] FAIL midrst_sat: got %b want 0", sat); end
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (valid === 1'b1) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("[TB] FAIL midrst_no_valid: got %0d pulses want 0", pulses); end
   endtask

   task automatic test_load_while_busy();
      exp_t e;
      int   cyc;
      int   pulses;
      logic [BCD_W-1:0] prior;
      e = model(321);
      prior = e.bcd;
      sb.push_back(e);
      load   = 1'b1;
      bin_in = 14'd321;
      tick();
      load = 1'b0;
      waitForValid(20, cyc);
      total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL lwb_prime_valid: got %b want 1", valid); end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         total++; if (bcd_out !== e.bcd) begin bad++; $display("[TB] FAIL lwb_prime_bcd: got %h want %h", bcd_out, e.bcd); end
      end
      e = model(5678);
      sb.push_back(e);
      load   = 1'b1;
      bin_in = 14'd5678;
      tick();
      load   = 1'b0;
      bin_in = 14'd42;
      for (int c = 1; c <= 14; c++) begin
         total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL lwb_busy c=%0d: got %b want 1", c, busy); end
         total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL lwb_early_valid c=%0d: got %b want 0", c, valid); end
         total++; if (bcd_out !== prior) begin bad++; $display("[TB] FAIL lwb_hold c=%0d: got %h want %h", c, bcd_out, prior); end
         load = ((c == 3) || (c == 10)) ? 1'b1 : 1'b0;
         tick();
      end
      total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL lwb_valid: got %b want 1", valid); end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         total++; if (bcd_out !== e.bcd) begin bad++; $display("[TB] FAIL lwb_bcd: got %h want %h", bcd_out, e.bcd); end
         total++; if (sat !== e.sat) begin bad++; $display("[TB] FAIL lwb_sat: got %b want %b", sat, e.sat); end
      end
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (valid === 1'b1) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("[TB] FAIL lwb_extra_valid: got %0d pulses want 0", pulses); end
      total++; if (bcd_out !== e.bcd) begin bad++; $display("[TB] FAIL lwb_final_hold: got %h want %h", bcd_out, e.bcd); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   cyc;
      sb.push_back(model(100));
      load   = 1'b1;
      bin_in = 14'd100;
      tick();
      bin_in = 14'd7;
      waitForValid(20, cyc);
      total++;
      if ((valid !== 1'b1) || (cyc != 14)) begin
         bad++; $display("[TB] FAIL b2b_first_latency: got valid=%b after %0d cycles want valid=1 after 14", valid, cyc);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         total++; if (bcd_out !== e.bcd) begin bad++; $display("[TB] FAIL b2b_first_bcd: got %h want %h", bcd_out, e.bcd); end
      end
      sb.push_back(model(7));
      tick();
      load = 1'b0;
      waitForValid(20, cyc);
      total++;
      if ((valid !== 1'b1) || (cyc != 14)) begin
         bad++; $display("[TB] FAIL b2b_second_spacing: got valid=%b after %0d cycles want valid=1 after 14", valid, cyc);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         total++; if (bcd_out !== e.bcd) begin bad++; $display("[TB] FAIL b2b_second_bcd: got %h want %h", bcd_out, e.bcd); end
         total++; if (sat !== e.sat) begin bad++; $display("[TB] FAIL b2b_second_sat: got %b want %b", sat, e.sat); end
      end
   endtask

   task automatic test_sweep();
      int   extras[6] = '{1, 9998, 9999, 10000, 10001, 16383};
      exp_t e;
      int   cyc;
      int   v;
      logic digitsOk;
      for (int i = 0; i < 2347; i++) begin
         v = (i < 2341) ? (i * 7 + (i % 7)) : extras[i - 2341];
         sb.push_back(model(v));
         load   = 1'b1;
         bin_in = BIN_W'(v);
         tick();
         load = 1'b0;
         waitForValid(20, cyc);
         total++;
         if ((valid !== 1'b1) || (cyc != 14)) begin
            bad++; $display("[TB] FAIL sweep_latency v=%0d: got valid=%b after %0d cycles want valid=1 after 14", v, valid, cyc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            total++; if (bcd_out !== e.bcd) begin bad++; $display("[TB] FAIL sweep_bcd v=%0d: got %h want %h", e.val, bcd_out, e.bcd); end
            total++; if (sat !== e.sat) begin bad++; $display("[TB] FAIL sweep_sat v=%0d: got %b want %b", e.val, sat, e.sat); end
         end
`ifndef SCORE_LEADING_ZERO_BLANK_EN
         digitsOk = 1'b1;
         for (int d = 0; d < DIGITS; d++) begin
            if (!(bcd_out[4*d +: 4] <= 4'd9)) digitsOk = 1'b0;
         end
         total++; if (digitsOk !== 1'b1) begin bad++; $display("[TB] FAIL sweep_digit_range v=%0d: got %h want all nibbles <= 9", v, bcd_out); end
`else
         digitsOk = 1'b1;
`endif
      end
   endtask

   initial begin
      $display("[TB] starting score_bcd_converter bench");
      test_reset();
      test_basic();
      test_boundaries();
      test_reset_mid_conversion();
      test_load_while_busy();
      test_back_to_back();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
